// File: rtl/cla_pkg.sv
// Shared constants, FSM state type and the golden CLA function for the
// 4-bit adder response checker.
package cla_pkg;

    localparam int CLA_W   = 4;
    localparam int CARRY_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } chk_state_t;

    // Returns {carry vector, sum}; carry[0] is cin and carry[CLA_W] is carry out.
    function automatic logic [CARRY_W+CLA_W-1:0] cla_expected(
        input logic [CLA_W-1:0] a,
        input logic [CLA_W-1:0] b,
        input logic             cin
    );
        logic [CARRY_W-1:0] cv;
        logic [CLA_W-1:0]   sv;
        cv    = '0;
        sv    = '0;
        cv[0] = cin;
        for (int i = 0; i < CLA_W; i++) begin
            cv[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & cv[i]);
            sv[i]   = a[i] ^ b[i] ^ cv[i];
        end
        return {cv, sv};
    endfunction

endpackage

// File: rtl/cla_ref_model.sv
// Purely combinational golden model: expected sum and full carry vector
// of a 4-bit carry-lookahead adder.
module cla_ref_model
    import cla_pkg::*;
(
    input  logic [CLA_W-1:0]   a,
    input  logic [CLA_W-1:0]   b,
    input  logic               cin,
    output logic [CLA_W-1:0]   e_s,
    output logic [CARRY_W-1:0] e_c
);

    assign {e_c, e_s} = cla_expected(a, b, cin);

endmodule

// File: rtl/cla_response_checker.sv
// BIST response analyser for a 4-bit CLA: accepts NUM_VECTORS tuples,
// counts mismatches against a golden model and captures the first failure.
module cla_response_checker
    import cla_pkg::*;
#(
    parameter int NUM_VECTORS = 18,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 vec_valid,
    output logic                 vec_ready,
    input  logic [CLA_W-1:0]     a,
    input  logic [CLA_W-1:0]     b,
    input  logic                 cin,
    input  logic [CLA_W-1:0]     s,
    input  logic [CARRY_W-1:0]   c,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     vec_count,
    output logic [CNT_W-1:0]     err_count,
    output logic                 fail_valid,
    output logic [CLA_W-1:0]     fail_a,
    output logic [CLA_W-1:0]     fail_b,
    output logic                 fail_cin,
    output logic [CLA_W-1:0]     fail_s,
    output logic [CARRY_W-1:0]   fail_c
);

    localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS - 1);

    chk_state_t state_q, state_d;
    logic       run_start;
    logic       accept;

    logic                 s1_valid;
    logic [CLA_W-1:0]     s1_a, s1_b, s1_s;
    logic                 s1_cin;
    logic [CARRY_W-1:0]   s1_c;
    logic [CLA_W-1:0]     e_s;
    logic [CARRY_W-1:0]   e_c;
    logic                 mismatch;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        vec_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        run_start = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    run_start = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                vec_ready = (vec_count < NUM_CNT);
                accept    = vec_valid && vec_ready;
                if (accept && (vec_count == LAST_CNT)) state_d = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pass = done && (err_count == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: tuple payload flops carry no reset; s1_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a   <= a;
            s1_b   <= b;
            s1_cin <= cin;
            s1_s   <= s;
            s1_c   <= c;
        end
    end

    cla_ref_model u_ref (
        .a   (s1_a),
        .b   (s1_b),
        .cin (s1_cin),
        .e_s (e_s),
        .e_c (e_c)
    );

    assign mismatch = s1_valid && ((s1_s != e_s) || (s1_c != e_c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
            fail_s     <= '0;
            fail_c     <= '0;
        end else if (run_start) begin
            s1_valid   <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
            fail_s     <= '0;
            fail_c     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept && (vec_count != '1)) vec_count <= vec_count + 1'b1;
            if (mismatch) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_a     <= s1_a;
                    fail_b     <= s1_b;
                    fail_cin   <= s1_cin;
                    fail_s     <= s1_s;
                    fail_c     <= s1_c;
                end
            end
        end
    end

endmodule
